ro_pair_sequencer: RTL and testbench

Parametrised measurement sequencer for the ring-oscillator array. It walks through NUM_PAIRS oscillator pairs. For each pair it clears the external edge counters, enables the pair for a fixed gate window, waits for the counters to settle, and then compares the two counts to form one response bit. It replaces the fixed 4-pair controller and adds configurable window length, a settle phase, tie detection, abort and a registered response vector.

---
 rtl/ro_pkg.sv | 23 ++
 rtl/ro_window_timer.sv | 29 ++
 rtl/ro_pair_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_ro_pair_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared definitions for the ring-oscillator measurement blocks: state
// encoding, default counter/window sizes and a small sizing helper.
package ro_pkg;

    localparam int DEF_CNT_W         = 16;
    localparam int DEF_WIN_CYCLES    = 1024;
    localparam int DEF_SETTLE_CYCLES = 4;

    // Sequencer states, kept as plain constants so older code that compares
    // raw 3-bit codes keeps working.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // Larger of two integers, used to size the shared window timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_window_timer.sv
// Loadable down-counter shared by the gate window and the settle phase.
// A load wins over a decrement; the count parks at zero.
module ro_window_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Count register: load, decrement towards zero, or hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/ro_pair_sequencer.sv
// Measurement sequencer for the ring-oscillator array. For each pair it
// clears the edge counters, gates the pair for a fixed window, waits for the
// counter synchronisers to settle and then records one response bit and one
// tie bit. All outputs come straight from registers.
module ro_pair_sequencer
    import ro_pkg::*;
#(
    parameter int NUM_PAIRS     = 4,
    parameter int SEL_W         = $clog2(NUM_PAIRS),
    parameter int CNT_W         = DEF_CNT_W,
    parameter int WIN_CYCLES    = DEF_WIN_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic                 enable,
    output logic                 cnt_clear,
    output logic [SEL_W-1:0]     pair_select,
    input  logic [CNT_W-1:0]     cnt_a,
    input  logic [CNT_W-1:0]     cnt_b,
    output logic [NUM_PAIRS-1:0] resp,
    output logic [NUM_PAIRS-1:0] tie,
    output logic                 busy,
    output logic                 done
);

    localparam int TW = $clog2(max_int(WIN_CYCLES, SETTLE_CYCLES) + 1);

    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_PAIRS - 1);
    localparam logic [TW-1:0]    WIN_LOAD    = TW'(WIN_CYCLES - 1);
    localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

    logic [2:0]           state_reg,  state_next;
    logic                 enable_reg, enable_next;
    logic                 clear_reg,  clear_next;
    logic [SEL_W-1:0]     sel_reg,    sel_next;
    logic [NUM_PAIRS-1:0] resp_reg,   resp_next;
    logic [NUM_PAIRS-1:0] tie_reg,    tie_next;
    logic                 busy_reg,   busy_next;
    logic                 done_reg,   done_next;

    logic                 t_load;
    logic                 t_dec;
    logic [TW-1:0]        t_load_value;
    logic                 t_zero;

    logic                 cap_gt;
    logic                 cap_eq;
    logic [NUM_PAIRS-1:0] sel_hot;
    logic [NUM_PAIRS-1:0] resp_cap;
    logic [NUM_PAIRS-1:0] tie_cap;

    ro_window_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (t_load),
        .dec        (t_dec),
        .load_value (t_load_value),
        .zero       (t_zero)
    );

    // Counts are compared as raw unsigned values; wrap is the source's job.
    assign cap_gt = (cnt_a > cnt_b);
    assign cap_eq = (cnt_a == cnt_b);

    // Only the bit of the pair under measurement takes the new result.
    generate
        for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_cap
            assign sel_hot[gi]  = (sel_reg == SEL_W'(gi));
            assign resp_cap[gi] = sel_hot[gi] ? cap_gt : resp_reg[gi];
            assign tie_cap[gi]  = sel_hot[gi] ? cap_eq : tie_reg[gi];
        end
    endgenerate

    // Next-state and next-output logic; abort overrides everything.
    always_comb begin
        state_next   = state_reg;
        enable_next  = 1'b0;
        clear_next   = 1'b0;
        sel_next     = sel_reg;
        resp_next    = resp_reg;
        tie_next     = tie_reg;
        busy_next    = busy_reg;
        done_next    = done_reg;
        t_load       = 1'b0;
        t_dec        = 1'b0;
        t_load_value = '0;

        if (abort) begin
            state_next = ST_IDLE;
            sel_next   = '0;
            resp_next  = '0;
            tie_next   = '0;
            busy_next  = 1'b0;
            done_next  = 1'b0;
            t_load     = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_next = ST_CLEAR;
                        clear_next = 1'b1;
                        sel_next   = '0;
                        resp_next  = '0;
                        tie_next   = '0;
                        busy_next  = 1'b1;
                        done_next  = 1'b0;
                    end
                end
                ST_CLEAR: begin
                    state_next   = ST_RUN;
                    enable_next  = 1'b1;
                    t_load       = 1'b1;
                    t_load_value = WIN_LOAD;
                end
                ST_RUN: begin
                    if (t_zero) begin
                        state_next   = ST_SETTLE;
                        t_load       = 1'b1;
                        t_load_value = SETTLE_LOAD;
                    end else begin
                        enable_next = 1'b1;
                        t_dec       = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (t_zero) begin
                        state_next = ST_CAPTURE;
                    end else begin
                        t_dec = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    resp_next = resp_cap;
                    tie_next  = tie_cap;
                    if (sel_reg == LAST_SEL) begin
                        state_next = ST_DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_CLEAR;
                        clear_next = 1'b1;
                        sel_next   = sel_reg + SEL_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    sel_next   = '0;
                    busy_next  = 1'b0;
                    done_next  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset clears them without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            enable_reg <= 1'b0;
            clear_reg  <= 1'b0;
            sel_reg    <= '0;
            resp_reg   <= '0;
            tie_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            enable_reg <= enable_next;
            clear_reg  <= clear_next;
            sel_reg    <= sel_next;
            resp_reg   <= resp_next;
            tie_reg    <= tie_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign enable      = enable_reg;
    assign cnt_clear   = clear_reg;
    assign pair_select = sel_reg;
    assign resp        = resp_reg;
    assign tie         = tie_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_ro_pair_sequencer.sv
// Randomised self-checking bench for ro_pair_sequencer. The reference model
// holds per-pair counts in arrays and derives expected resp/tie, latency and
// gate-window lengths directly from the measurement rules.
module tb_ro_pair_sequencer;

    localparam int NP  = 4;
    localparam int NP3 = 3;
    localparam int WIN = 8;
    localparam int SET = 2;
    localparam int CW  = 16;
    localparam int LAT = 1 + WIN + SET + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic start3 = 1'b0;

    logic          enable, cnt_clear, busy, done;
    logic [1:0]    pair_select;
    logic [CW-1:0] cnt_a, cnt_b;
    logic [NP-1:0] resp, tie;

    logic           enable3, cnt_clear3, busy3, done3;
    logic [1:0]     pair_select3;
    logic [CW-1:0]  cnt_a3, cnt_b3;
    logic [NP3-1:0] resp3, tie3;

    // Model of the oscillator counts for each pair.
    logic [CW-1:0] ca [NP];
    logic [CW-1:0] cb [NP];
    logic [CW-1:0] ca3 [NP3];
    logic [CW-1:0] cb3 [NP3];

    assign cnt_a  = ca[pair_select];
    assign cnt_b  = cb[pair_select];
    assign cnt_a3 = (pair_select3 < 2'd3) ? ca3[pair_select3] : '0;
    assign cnt_b3 = (pair_select3 < 2'd3) ? cb3[pair_select3] : '0;

    ro_pair_sequencer #(
        .NUM_PAIRS (NP), .CNT_W (CW), .WIN_CYCLES (WIN), .SETTLE_CYCLES (SET)
    ) dut (
        .clk (clk), .reset (reset), .start (start), .abort (abort),
        .enable (enable), .cnt_clear (cnt_clear), .pair_select (pair_select),
        .cnt_a (cnt_a), .cnt_b (cnt_b), .resp (resp), .tie (tie),
        .busy (busy), .done (done)
    );

    ro_pair_sequencer #(
        .NUM_PAIRS (NP3), .CNT_W (CW), .WIN_CYCLES (WIN), .SETTLE_CYCLES (SET)
    ) dut3 (
        .clk (clk), .reset (reset), .start (start3), .abort (1'b0),
        .enable (enable3), .cnt_clear (cnt_clear3), .pair_select (pair_select3),
        .cnt_a (cnt_a3), .cnt_b (cnt_b3), .resp (resp3), .tie (tie3),
        .busy (busy3), .done (done3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Observers: gate cycles per pair, clear-pulse order, highest 3-pair select.
    int en_cnt [NP];
    int clr_order [$];
    int max_sel3 = 0;

    always @(negedge clk) begin
        if (enable) en_cnt[pair_select]++;
        if (cnt_clear) clr_order.push_back(int'(pair_select));
        if (int'(pair_select3) > max_sel3) max_sel3 = int'(pair_select3);
    end

    task automatic clear_obs();
        for (int p = 0; p < NP; p++) en_cnt[p] = 0;
        clr_order.delete();
    endtask

    function automatic logic [NP-1:0] exp_resp();
        logic [NP-1:0] r;
        for (int p = 0; p < NP; p++) r[p] = (ca[p] > cb[p]);
        return r;
    endfunction

    function automatic logic [NP-1:0] exp_tie();
        logic [NP-1:0] t;
        for (int p = 0; p < NP; p++) t[p] = (ca[p] == cb[p]);
        return t;
    endfunction

    task automatic rand_pairs();
        for (int p = 0; p < NP; p++) begin
            ca[p] = CW'($urandom);
            case ($urandom_range(0, 2))
                0:       cb[p] = ca[p];
                1:       cb[p] = CW'($urandom);
                default: cb[p] = ca[p] ^ CW'(1);
            endcase
        end
    endtask

    // Wait for done, counting negedges; returns the count (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Sequence-level checks once done has been observed.
    task automatic check_result(input string tag, input int cyc);
        chk({tag, ".latency"}, cyc, NP * LAT);
        chk({tag, ".resp"}, 32'(resp), 32'(exp_resp()));
        chk({tag, ".tie"}, 32'(tie), 32'(exp_tie()));
        chk({tag, ".busy_done"}, 32'(busy), 0);
        for (int p = 0; p < NP; p++) chk({tag, ".en_cycles"}, en_cnt[p], WIN);
        chk({tag, ".n_clear"}, clr_order.size(), NP);
        for (int i = 0; i < NP && i < clr_order.size(); i++)
            chk({tag, ".sel_order"}, clr_order[i], i);
        $display("seq %s: cycles=%0d resp=%b tie=%b", tag, cyc, resp, tie);
    endtask

    // One complete sequence started by a one-cycle start pulse.
    task automatic run_seq(input string tag);
        int cyc;
        clear_obs();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 1);
        chk({tag, ".clear"}, 32'(cnt_clear), 1);
        chk({tag, ".sel0"}, 32'(pair_select), 0);
        chk({tag, ".resp_cleared"}, 32'(resp), 0);
        wait_done(cyc);
        check_result(tag, cyc);
    endtask

    initial begin
        int cyc;
        for (int p = 0; p < NP; p++) begin ca[p] = '0; cb[p] = '0; end
        for (int p = 0; p < NP3; p++) begin ca3[p] = '0; cb3[p] = '0; end

        // Reset values
        @(negedge clk);
        chk("rst.enable", 32'(enable), 0);
        chk("rst.clear", 32'(cnt_clear), 0);
        chk("rst.sel", 32'(pair_select), 0);
        chk("rst.resp", 32'(resp), 0);
        chk("rst.tie", 32'(tie), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        reset = 1'b0;
        @(negedge clk);

        // Pairs 0 and 2 win, no ties
        ca[0] = 16'd100;  cb[0] = 16'd50;
        ca[1] = 16'd10;   cb[1] = 16'd20;
        ca[2] = 16'd7;    cb[2] = 16'd3;
        ca[3] = 16'd1;    cb[3] = 16'd2;
        run_seq("dir_0101");

        // Pair 1 ties at 0x1234
        ca[1] = 16'h1234; cb[1] = 16'h1234;
        run_seq("dir_tie");

        // Randomised sequences
        for (int s = 0; s < 6; s++) begin
            rand_pairs();
            run_seq($sformatf("rand%0d", s));
        end

        // Abort in RUN of pair 2
        ca[0] = 16'd9; cb[0] = 16'd1; ca[1] = 16'd5; cb[1] = 16'd5;
        clear_obs();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(pair_select == 2'd2 && enable) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort.reach_run2", 32'(cyc < 200), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort.enable", 32'(enable), 0);
        chk("abort.clear", 32'(cnt_clear), 0);
        chk("abort.resp", 32'(resp), 0);
        chk("abort.tie", 32'(tie), 0);
        chk("abort.done", 32'(done), 0);
        chk("abort.busy", 32'(busy), 0);
        chk("abort.sel", 32'(pair_select), 0);
        $display("abort: idle after abort, sel=%0d", pair_select);
        rand_pairs();
        run_seq("after_abort");

        // Asynchronous reset in SETTLE of pair 1
        ca[0] = 16'd200; cb[0] = 16'd100;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < LAT + 1 + WIN; i++) @(negedge clk);
        chk("rst_mid.pre_sel", 32'(pair_select), 1);
        chk("rst_mid.pre_enable", 32'(enable), 0);
        chk("rst_mid.pre_busy", 32'(busy), 1);
        chk("rst_mid.pre_resp", 32'(resp), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.enable", 32'(enable), 0);
        chk("rst_mid.busy", 32'(busy), 0);
        chk("rst_mid.sel", 32'(pair_select), 0);
        chk("rst_mid.resp", 32'(resp), 0);
        $display("reset: asserted between edges in settle");
        #1 reset = 1'b0;
        rand_pairs();
        run_seq("after_reset");

        // start held high: back-to-back sequences
        rand_pairs();
        clear_obs();
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        wait_done(cyc);
        check_result("b2b_first", cyc);
        clear_obs();
        @(negedge clk);
        chk("b2b.done_one_cycle", 32'(done), 0);
        chk("b2b.busy", 32'(busy), 1);
        chk("b2b.resp_cleared", 32'(resp), 0);
        chk("b2b.clear", 32'(cnt_clear), 1);
        rand_pairs();
        wait_done(cyc);
        start = 1'b0;
        check_result("b2b_second", cyc);
        @(negedge clk);
        chk("b2b.done_held", 32'(done), 1);

        // Three-pair instance
        for (int p = 0; p < NP3; p++) begin
            ca3[p] = CW'($urandom_range(0, 3));
            cb3[p] = CW'($urandom_range(0, 3));
        end
        max_sel3 = 0;
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        cyc = 0;
        while (!done3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        begin
            logic [NP3-1:0] er3, et3;
            for (int p = 0; p < NP3; p++) begin
                er3[p] = (ca3[p] > cb3[p]);
                et3[p] = (ca3[p] == cb3[p]);
            end
            chk("np3.latency", cyc, NP3 * LAT);
            chk("np3.resp", 32'(resp3), 32'(er3));
            chk("np3.tie", 32'(tie3), 32'(et3));
            chk("np3.max_sel", max_sel3, NP3 - 1);
            $display("seq np3: cycles=%0d resp=%b tie=%b max_sel=%0d", cyc, resp3, tie3, max_sel3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
